tile_sched_ctrl: RTL and testbench
==================================

Name: tile_sched_ctrl

Overview:
Parametrised successor to the systolic-array operand address controller. It walks a full tiled matrix multiply C[ROWS x COLS] = A[ROWS x DEPTH] * B[DEPTH x COLS] on an N1 x N2 MAC array. For each tile it generates the A and B buffer read addresses, accumulator-clear and tile-complete strobes, and a drain phase for systolic skew. A start/busy/done handshake and a stall input replace the previous free-running counters.

Parameters:
N1, 4, array rows (A slice height)
N2, 4, array columns (B slice width)
ROWS, 8, rows of A / C; ROWS % N1 == 0
COLS, 8, columns of B / C; COLS % N2 == 0
DEPTH, 8, shared inner dimension; DEPTH >= 2
RS_W, max(1,$clog2(ROWS/N1)), row-slice counter width
CS_W, max(1,$clog2(COLS/N2)), col-slice counter width
K_W, max(1,$clog2(DEPTH)), inner counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin operation; sampled only in IDLE
stall  in  1  hold feed (operand buffer not ready)
busy  out  1  operation in progress
done  out  1  one-cycle pulse at completion
rd_en  out  1  A and B buffer read enable
rd_addr_A  out  $clog2((ROWS/N1)*DEPTH) (min 1)  A buffer address
rd_addr_B  out  $clog2((COLS/N2)*DEPTH) (min 1)  B buffer address
acc_clr  out  1  clear array accumulators (first feed cycle of tile)
tile_valid  out  1  one-cycle pulse: accumulators hold final tile result
tile_row  out  RS_W  row slice of current tile
tile_col  out  CS_W  col slice of current tile

Behaviour:
- Reset (rst low, asynchronous, any time, including mid-operation): state IDLE, k/drain/rs/cs counters 0, all outputs 0. Operation restarts only on a fresh start.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 -> FEED with k=0, rs=0, cs=0. start is ignored in all other states, including DONE.
- FEED, stall=0: rd_en=1, k increments. At k=DEPTH-1 -> DRAIN, drain counter=0.
- FEED, stall=1: rd_en=0; k, addresses and state held.
- acc_clr=1 only in the FEED cycle with k==0 and rd_en=1. A stall at k=0 delays it.
- Addresses are combinational from registered counters, valid whenever rd_en=1:
  - rd_addr_A = k + rs*DEPTH
  - rd_addr_B = k + cs*DEPTH
  - Addresses are 0 in IDLE.
- DRAIN: lasts DRAIN_CYC = N1+N2-1 cycles; rd_en=0; stall is ignored. tile_valid pulses on the last DRAIN cycle, with tile_row=rs and tile_col=cs.
- After DRAIN (column-major inside row):
  - cs < COLS/N2-1: cs+1 -> FEED, k=0.
  - else if rs < ROWS/N1-1: cs=0, rs+1 -> FEED.
  - else -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE with counters cleared.
- busy=1 in FEED, DRAIN and DONE; 0 in IDLE.
- No-stall timing:
  - Per tile: DEPTH + DRAIN_CYC cycles.
  - done is asserted 1 + T*(DEPTH+DRAIN_CYC) cycles after the start-sample edge, where T = (ROWS/N1)*(COLS/N2).
- Counter wrap: k, rs and cs never exceed their maxima. Widths come from the parameters above, so no overflow is possible.

Optional Feature:
Macro TILE_SCHED_PERF_EN.
- Defined: adds output perf_cycles [31:0].
  - Cleared on the start-sample edge.
  - Increments every cycle busy=1, stall cycles included.
  - Saturates at 32'hFFFF_FFFF.
  - Holds its value in IDLE until the next start; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset/idle (defaults): hold rst low, release, 5 idle cycles -> busy, done, rd_en, acc_clr, tile_valid = 0; rd_addr_A = rd_addr_B = 0.
- Full run, no stall (defaults: T=4, DRAIN_CYC=7):
  - done pulses 61 cycles after the start sample; busy high for exactly 61 cycles.
  - 32 rd_en cycles and 4 tile_valid pulses with (row,col) = (0,0), (0,1), (1,0), (1,1).
- Address check: in tile (1,0) at k=3 -> rd_addr_A=11, rd_addr_B=3; in tile (0,1) at k=7 -> rd_addr_A=7, rd_addr_B=15.
- Stall: assert stall for 3 cycles at k=5 of tile 0 -> rd_en=0 and addresses frozen at (5,5); resume at k=5; done at 64 cycles. Stall asserted during DRAIN has no effect.
- Protocol edges:
  - start held high through the run -> ignored until IDLE, restarts the cycle after done.
  - rst pulsed low mid-DRAIN -> all outputs 0 immediately, no done pulse.
- Non-square (N1=2, N2=4, ROWS=4, COLS=8, DEPTH=3):
  - T=4, DRAIN_CYC=5; done after 33 cycles.
  - With TILE_SCHED_PERF_EN, perf_cycles=33.

Source files
------------

// File: rtl/tile_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tile_sched_ctrl
//
// Operand address sequencer for a tiled matrix multiply
//   C[ROWS x COLS] = A[ROWS x DEPTH] * B[DEPTH x COLS]
// on an N1 x N2 systolic MAC array.
//
// Each tile is fed for DEPTH cycles, then drained for N1+N2-1 cycles so the
// skewed wavefront reaches every accumulator. Tiles are visited column-major
// inside a row slice: (rs,cs) = (0,0), (0,1), ... (1,0), (1,1), ...
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       begin an operation (sampled only while idle)
//   stall       operand buffer not ready; holds the feed (ignored in drain)
//   busy        operation in progress (FEED, DRAIN, DONE)
//   done        one-cycle completion pulse
//   rd_en       A/B buffer read enable
//   rd_addr_A   A buffer address = k + rs*DEPTH
//   rd_addr_B   B buffer address = k + cs*DEPTH
//   acc_clr     clear accumulators on the first feed beat of a tile
//   tile_valid  one-cycle pulse: accumulators hold the finished tile
//   tile_row    row slice of the current tile
//   tile_col    column slice of the current tile
//   perf_cycles busy-cycle counter, saturating (only with TILE_SCHED_PERF_EN)
//
// Optional build macro: TILE_SCHED_PERF_EN adds the perf_cycles output.
// -----------------------------------------------------------------------------
module tile_sched_ctrl #(
  parameter int N1    = 4,
  parameter int N2    = 4,
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DEPTH = 8,
  parameter int RS_W  = ((ROWS / N1) > 1) ? $clog2(ROWS / N1) : 1,
  parameter int CS_W  = ((COLS / N2) > 1) ? $clog2(COLS / N2) : 1,
  parameter int K_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  // Address widths follow from the geometry; leave at their defaults.
  parameter int AW_A  = (((ROWS / N1) * DEPTH) > 1) ? $clog2((ROWS / N1) * DEPTH) : 1,
  parameter int AW_B  = (((COLS / N2) * DEPTH) > 1) ? $clog2((COLS / N2) * DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW_A-1:0] rd_addr_A,
  output logic [AW_B-1:0] rd_addr_B,
  output logic            acc_clr,
  output logic            tile_valid,
  output logic [RS_W-1:0] tile_row,
  output logic [CS_W-1:0] tile_col
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam int ROW_TILES = ROWS / N1;
  localparam int COL_TILES = COLS / N2;
  localparam int DRAIN_CYC = N1 + N2 - 1;
  localparam int D_W       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [K_W-1:0]  K_LAST  = K_W'(DEPTH - 1);
  localparam logic [D_W-1:0]  D_LAST  = D_W'(DRAIN_CYC - 1);
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(ROW_TILES - 1);
  localparam logic [CS_W-1:0] CS_LAST = CS_W'(COL_TILES - 1);
  // Only multiplied by a slice index, so truncation in a single-slice
  // configuration is harmless (the index is always 0 there).
  localparam logic [AW_A-1:0] DEPTH_A = AW_A'(DEPTH);
  localparam logic [AW_B-1:0] DEPTH_B = AW_B'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [K_W-1:0]  k;
  logic [D_W-1:0]  dcnt;
  logic [RS_W-1:0] rs;
  logic [CS_W-1:0] cs;

  logic k_last;
  logic d_last;
  logic rs_last;
  logic cs_last;

  assign k_last  = (k == K_LAST);
  assign d_last  = (dcnt == D_LAST);
  assign rs_last = (rs == RS_LAST);
  assign cs_last = (cs == CS_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (!stall && k_last) state_nxt = DRAIN;
      DRAIN:   if (d_last) state_nxt = (rs_last && cs_last) ? DONE : FEED;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tile / inner / drain counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k    <= '0;
      dcnt <= '0;
      rs   <= '0;
      cs   <= '0;
    end else begin
      case (state)
        FEED: begin
          if (!stall) begin
            if (k_last) begin
              k    <= '0;
              dcnt <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (d_last) begin
            dcnt <= '0;
            if (!cs_last) begin
              cs <= cs + 1'b1;
            end else if (!rs_last) begin
              cs <= '0;
              rs <= rs + 1'b1;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE: everything parked at zero for the next start.
          k    <= '0;
          dcnt <= '0;
          rs   <= '0;
          cs   <= '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    tile_valid = 1'b0;
    case (state)
      FEED: begin
        busy  = 1'b1;
        rd_en = !stall;
      end
      DRAIN: begin
        busy       = 1'b1;
        tile_valid = d_last;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // A stall on the first beat pushes the clear to the beat actually consumed.
  assign acc_clr   = rd_en && (k == '0);
  assign rd_addr_A = AW_A'(k) + AW_A'(rs) * DEPTH_A;
  assign rd_addr_B = AW_B'(k) + AW_B'(cs) * DEPTH_B;
  assign tile_row  = rs;
  assign tile_col  = cs;

`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_sched_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for tile_sched_ctrl. Stimulus tasks push the expected read beats,
// tile pulses, done events and point probes into queues; a negedge monitor
// pops and compares them whenever the DUT presents the matching output.
// A second instance covers a non-square geometry.
// -----------------------------------------------------------------------------
module tb_tile_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic       busy, done, rd_en, acc_clr, tile_valid;
  logic [3:0] rd_addr_A, rd_addr_B;
  logic [0:0] tile_row, tile_col;

  logic       start2 = 1'b0;
  logic       busy2, done2, rd_en2, acc_clr2, tile_valid2;
  logic [2:0] rd_addr_A2, rd_addr_B2;
  logic [0:0] tile_row2, tile_col2;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_cycles2;
`endif

  always #5 clk = ~clk;

  tile_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
    .acc_clr(acc_clr), .tile_valid(tile_valid),
    .tile_row(tile_row), .tile_col(tile_col)
`ifdef TILE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  tile_sched_ctrl #(.N1(2), .N2(4), .ROWS(4), .COLS(8), .DEPTH(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stall(1'b0),
    .busy(busy2), .done(done2), .rd_en(rd_en2),
    .rd_addr_A(rd_addr_A2), .rd_addr_B(rd_addr_B2),
    .acc_clr(acc_clr2), .tile_valid(tile_valid2),
    .tile_row(tile_row2), .tile_col(tile_col2)
`ifdef TILE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles2)
`endif
  );

  typedef struct { int cyc; int a; int b; int clr; } rd_t;
  typedef struct { int cyc; int row; int col; } tile_t;
  typedef struct { int cyc; int busy_n; } done_t;
  typedef struct { int cyc; int busy; int en; int a; int b; } probe_t;

  rd_t    rd_q[$];
  tile_t  tile_q[$];
  done_t  done_q[$];
  probe_t probe_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;      // cycle index since the start-sample edge (1 = first busy cycle)
  int busy_cnt = 0; // busy cycles completed before the current one

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc      <= 0;
      busy_cnt <= 0;
    end else if (!busy && start) begin
      cyc      <= 1;
      busy_cnt <= 0;
    end else if (busy) begin
      cyc      <= cyc + 1;
      busy_cnt <= busy_cnt + 1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          rd_t e;
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr_A", int'(rd_addr_A), e.a);
          chk("rd_addr_B", int'(rd_addr_B), e.b);
          chk("acc_clr", int'(acc_clr), e.clr);
        end
      end else if (acc_clr) begin
        chk("acc_clr_without_rd", 1, 0);
      end
      if (tile_valid) begin
        if (tile_q.size() == 0) chk("tile_unexpected", 1, 0);
        else begin
          tile_t t;
          t = tile_q.pop_front();
          chk("tile_cycle", cyc, t.cyc);
          chk("tile_row", int'(tile_row), t.row);
          chk("tile_col", int'(tile_col), t.col);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("busy_cycles", busy_cnt + 1, d.busy_n);
        end
      end
      if (probe_q.size() != 0 && probe_q[0].cyc == cyc) begin
        probe_t p;
        p = probe_q.pop_front();
        chk("probe_busy", int'(busy), p.busy);
        chk("probe_rd_en", int'(rd_en), p.en);
        chk("probe_addr_A", int'(rd_addr_A), p.a);
        chk("probe_addr_B", int'(rd_addr_B), p.b);
      end
    end
  end

  // Expected beats for one default-geometry run (4 tiles of 8 feed + 7 drain).
  // Tile 0 beats with k >= st_k, and everything after, slip by st_n cycles.
  task automatic push_run(input int st_k, input int st_n, input int ntiles);
    for (int t = 0; t < ntiles; t++) begin
      for (int k = 0; k < 8; k++) begin
        rd_t e;
        e.cyc = t * 15 + k + 1 + ((t > 0 || k >= st_k) ? st_n : 0);
        e.a   = k + (t / 2) * 8;
        e.b   = k + (t % 2) * 8;
        e.clr = (k == 0) ? 1 : 0;
        rd_q.push_back(e);
      end
    end
  endtask

  task automatic push_tiles(input int st_n);
    for (int t = 0; t < 4; t++) begin
      tile_t e;
      e.cyc = t * 15 + 15 + st_n;
      e.row = t / 2;
      e.col = t % 2;
      tile_q.push_back(e);
    end
  endtask

  task automatic push_done(input int c, input int b);
    done_t d;
    d.cyc = c;
    d.busy_n = b;
    done_q.push_back(d);
  endtask

  task automatic push_probe(input int c, input int b, input int en, input int a, input int bb);
    probe_t p;
    p.cyc = c; p.busy = b; p.en = en; p.a = a; p.b = bb;
    probe_q.push_back(p);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic chk_queues_empty(input string tag);
    chk({tag, "_rd_left"}, rd_q.size(), 0);
    chk({tag, "_tile_left"}, tile_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
    chk({tag, "_probe_left"}, probe_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_acc_clr"}, int'(acc_clr), 0);
    chk({tag, "_tile_valid"}, int'(tile_valid), 0);
    chk({tag, "_addr_A"}, int'(rd_addr_A), 0);
    chk({tag, "_addr_B"}, int'(rd_addr_B), 0);
  endtask

  initial begin
    int n_rd, n_tile, n_busy, dcyc;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("in_reset");
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk_idle_outputs("idle");

    // Full run, no stall, with two address probes
    push_run(8, 0, 4);
    push_tiles(0);
    push_done(61, 61);
    push_probe(23, 1, 1, 7, 15);
    push_probe(34, 1, 1, 11, 3);
    do_start();
    wait_done(200);
    repeat (3) @(posedge clk);
    chk_queues_empty("run");

    // Stall 3 cycles at tile 0 k=5, then stall during tile 1 drain
    push_run(5, 3, 4);
    push_tiles(3);
    push_done(64, 64);
    push_probe(6, 1, 0, 5, 5);
    push_probe(7, 1, 0, 5, 5);
    push_probe(8, 1, 0, 5, 5);
    push_probe(9, 1, 1, 5, 5);
    do_start();
    repeat (5) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    repeat (19) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(200);
    repeat (3) @(posedge clk);
    chk_queues_empty("stall");

    // start held high: one idle cycle after done, then a second run
    push_run(8, 0, 4);
    push_tiles(0);
    push_done(61, 61);
    push_probe(62, 0, 0, 0, 0);
    push_run(8, 0, 4);
    push_tiles(0);
    push_done(61, 61);
    @(posedge clk); #1 start = 1'b1;
    wait_done(200);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);
    repeat (3) @(posedge clk);
    chk_queues_empty("held_start");

    // Reset in the middle of tile 0 drain
    push_run(8, 0, 1);
    do_start();
    repeat (11) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk_idle_outputs("mid_drain_rst");
    chk("mid_drain_rst_tile_row", int'(tile_row), 0);
    chk("mid_drain_rst_tile_col", int'(tile_col), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (80) @(posedge clk);
    #1 chk("after_rst_busy", int'(busy), 0);
    chk_queues_empty("mid_drain_rst");

    // Non-square geometry on the second instance
    n_rd = 0; n_tile = 0; n_busy = 0; dcyc = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 1; i <= 100 && dcyc == 0; i++) begin
      @(negedge clk);
      if (rd_en2) n_rd++;
      if (tile_valid2) n_tile++;
      if (busy2) n_busy++;
      if (done2) dcyc = i;
    end
    chk("ns_done_cycle", dcyc, 33);
    chk("ns_rd_beats", n_rd, 12);
    chk("ns_tiles", n_tile, 4);
    chk("ns_busy_cycles", n_busy, 33);
    repeat (3) @(posedge clk);
    #1 chk("ns_idle_busy", int'(busy2), 0);
`ifdef TILE_SCHED_PERF_EN
    chk("ns_perf_cycles", int'(perf_cycles2), 33);
    chk("perf_cycles_hold", int'(perf_cycles), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
